// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller.
// Holds the phase (state) encodings and the lamp patterns {red,yellow,green}.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_HG    = 3'd0,  // highway green
        S_HY    = 3'd1,  // highway yellow
        S_AR1   = 3'd2,  // all red, highway -> farm
        S_FG    = 3'd3,  // farm green
        S_FY    = 3'd4,  // farm yellow
        S_AR2   = 3'd5,  // all red, farm/flash -> highway
        S_FLASH = 3'd6   // night flashing
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts cycles spent in the current phase.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, forces cnt to 0
//   clear - restart the count at 0 on the next edge (phase entry)
//   cnt   - cycles elapsed since phase entry, saturating at all-ones
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_gen2.sv
// Highway / farm-road intersection controller with pedestrian walk phase
// and night flashing mode.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset (returns to highway green)
//   c       - farm-road car sensor (level)
//   ped_req - pedestrian request (pulse or level), latched until served
//   night   - night-flash request (level), honoured only from highway green
//   hwy     - highway lamps {red,yellow,green}
//   farm    - farm-road lamps {red,yellow,green}
//   walk    - pedestrian walk lamp
//   phase   - current state encoding
module traffic_light_gen2
    import traffic_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int T_LONG  = 8,
    parameter int T_SHORT = 3,
    parameter int T_CLEAR = 2,
    parameter int T_WALK  = 4,
    parameter int T_FLASH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] hwy,
    output logic [2:0] farm,
    output logic       walk,
    output logic [2:0] phase
);

    localparam longint CNT_LIM = longint'(1) << CNT_W;

    if (T_LONG < 1 || longint'(T_LONG) >= CNT_LIM ||
        T_SHORT < 1 || longint'(T_SHORT) >= CNT_LIM ||
        T_CLEAR < 1 || longint'(T_CLEAR) >= CNT_LIM ||
        T_WALK < 1 || longint'(T_WALK) >= CNT_LIM ||
        T_FLASH < 1 || longint'(T_FLASH) >= CNT_LIM ||
        T_WALK > T_LONG) begin : g_bad_timing
        $error("traffic_light_gen2: illegal timing parameters");
    end

    // Last-cycle compare values, expressed at timer width.
    localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(T_LONG - 1);
    localparam logic [CNT_W-1:0] SHORT_END = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] CLEAR_END = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] WALK_END  = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] WALK_LEN  = CNT_W'(T_WALK);
    localparam logic [CNT_W-1:0] FLASH_LEN = CNT_W'(T_FLASH);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] flash_idx;
    logic             entering;
    logic             ped_pend;

    // Any state change restarts the phase timer.
    assign entering = (next_state != state);

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(entering),
        .cnt  (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_HG;
        end else begin
            state <= next_state;
        end
    end

    // Pedestrian request latch; clearing on FG entry beats a same-cycle request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend <= 1'b0;
        end else if (entering && next_state == S_FG) begin
            ped_pend <= 1'b0;
        end else if (ped_req && state != S_FG) begin
            ped_pend <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HG: begin
                if (night) begin
                    next_state = S_FLASH;
                end else if (cnt >= LONG_END && (c || ped_pend)) begin
                    next_state = S_HY;
                end
            end
            S_HY:    if (cnt == SHORT_END) next_state = S_AR1;
            S_AR1:   if (cnt == CLEAR_END) next_state = S_FG;
            S_FG: begin
                // Farm green ends early once traffic is gone and the walk time is served.
                if (cnt >= LONG_END || (!c && cnt >= WALK_END)) begin
                    next_state = S_FY;
                end
            end
            S_FY:    if (cnt == SHORT_END) next_state = S_AR2;
            S_AR2:   if (cnt == CLEAR_END) next_state = S_HG;
            S_FLASH: if (!night) next_state = S_AR2;
            default: next_state = S_HG;
        endcase
    end

    // Which half-period of the flash cycle we are in; even halves are lit.
    assign flash_idx = cnt / FLASH_LEN;

    always_comb begin
        hwy  = RED;
        farm = RED;
        walk = 1'b0;
        case (state)
            S_HG:  hwy = GRN;
            S_HY:  hwy = YEL;
            S_FG: begin
                farm = GRN;
                walk = (cnt < WALK_LEN);
            end
            S_FY:  farm = YEL;
            S_FLASH: begin
                if (flash_idx[0]) begin
                    hwy  = OFF;
                    farm = OFF;
                end else begin
                    hwy  = YEL;
                    farm = RED;
                end
            end
            default: begin
                hwy  = RED;
                farm = RED;
            end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_gen2.sv
module tb_traffic_light_gen2;
    import traffic_pkg::*;

    localparam int CNT_W   = 16;
    localparam int T_LONG  = 8;
    localparam int T_SHORT = 3;
    localparam int T_CLEAR = 2;
    localparam int T_WALK  = 4;
    localparam int T_FLASH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [2:0] hwy;
    logic [2:0] farm;
    logic       walk;
    logic [2:0] phase;

    int passed = 0;
    int total  = 0;

    traffic_light_gen2 #(
        .CNT_W(CNT_W), .T_LONG(T_LONG), .T_SHORT(T_SHORT),
        .T_CLEAR(T_CLEAR), .T_WALK(T_WALK), .T_FLASH(T_FLASH)
    ) dut (
        .clk(clk), .rst(rst), .c(c), .ped_req(ped_req), .night(night),
        .hwy(hwy), .farm(farm), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model: which phase we are in and how long we have been there.
    state_t m_ph;
    int     m_t;
    bit     m_pend;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int phase_len(input state_t p);
        case (p)
            S_HY, S_FY:   return T_SHORT;
            S_AR1, S_AR2: return T_CLEAR;
            default:      return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = S_HG;
        m_t = 0;
        m_pend = 0;
    endtask

    // One clock edge of the reference model, using the inputs present at the edge.
    task automatic model_step();
        state_t nxt;
        int     served;
        if (rst) begin
            model_reset();
            return;
        end
        served = m_t + 1;  // cycles spent in this phase including the current one
        nxt = m_ph;
        case (m_ph)
            S_HG:    if (night) nxt = S_FLASH;
                     else if (served >= T_LONG && (c || m_pend)) nxt = S_HY;
            S_HY:    if (served == phase_len(m_ph)) nxt = S_AR1;
            S_AR1:   if (served == phase_len(m_ph)) nxt = S_FG;
            S_FG:    if (served >= T_LONG || (!c && served >= T_WALK)) nxt = S_FY;
            S_FY:    if (served == phase_len(m_ph)) nxt = S_AR2;
            S_AR2:   if (served == phase_len(m_ph)) nxt = S_HG;
            S_FLASH: if (!night) nxt = S_AR2;
            default: nxt = S_HG;
        endcase
        if (nxt == S_FG && m_ph != S_FG) m_pend = 0;
        else if (ped_req && m_ph != S_FG) m_pend = 1;
        if (nxt != m_ph) m_t = 0;
        else if (m_t < (1 << CNT_W) - 1) m_t = m_t + 1;
        m_ph = nxt;
    endtask

    task automatic check_model(input string where);
        logic [2:0] eh, ef;
        logic       ew;
        ew = 0;
        case (m_ph)
            S_HG:  begin eh = 3'b001; ef = 3'b100; end
            S_HY:  begin eh = 3'b010; ef = 3'b100; end
            S_FG:  begin eh = 3'b100; ef = 3'b001; ew = (m_t < T_WALK); end
            S_FY:  begin eh = 3'b100; ef = 3'b010; end
            S_FLASH: begin
                if (((m_t / T_FLASH) % 2) == 0) begin eh = 3'b010; ef = 3'b100; end
                else begin eh = 3'b000; ef = 3'b000; end
            end
            default: begin eh = 3'b100; ef = 3'b100; end
        endcase
        chk({where, "_hwy"}, {5'd0, hwy}, {5'd0, eh});
        chk({where, "_farm"}, {5'd0, farm}, {5'd0, ef});
        chk({where, "_walk"}, {7'd0, walk}, {7'd0, ew});
        chk({where, "_phase"}, {5'd0, phase}, {5'd0, m_ph});
    endtask

    task automatic tick(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_model(where);
    endtask

    // Assert reset mid-cycle, check the asynchronous effect, hold across one edge, release.
    task automatic do_reset();
        #1 rst = 1;
        #1;
        model_reset();
        check_model("rst_async");
        tick("rst_hold");
        rst = 0;
    endtask

    task automatic wait_phase(input string tag, input state_t tgt, input int max_cyc);
        int n = 0;
        while (phase !== tgt && n < max_cyc) begin
            tick(tag);
            n++;
        end
        chk({tag, "_reached"}, {5'd0, phase}, {5'd0, tgt});
    endtask

    logic [2:0] cyc_ph [0:6];
    int         cyc_len[0:5];
    logic [2:0] flash_exp[0:7];
    int         fg_len, walk_cnt;

    initial begin
        model_reset();
        #2;
        check_model("reset_init");
        tick("reset_init_edge");
        rst = 0;

        // Idle: no cars, no pedestrians -> highway green forever.
        for (int i = 0; i < 50; i++) tick("idle");
        chk("idle_phase", {5'd0, phase}, {5'd0, S_HG});

        // Continuous farm traffic: fixed 26-cycle period.
        do_reset();
        c = 1;
        cyc_ph = '{S_HG, S_HY, S_AR1, S_FG, S_FY, S_AR2, S_HG};
        cyc_len = '{8, 3, 2, 8, 3, 2};
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 6; i++) begin
                for (int k = 1; k < cyc_len[i]; k++) tick("cycle");
                chk("cycle_hold", {5'd0, phase}, {5'd0, cyc_ph[i]});
                tick("cycle");
                chk("cycle_next", {5'd0, phase}, {5'd0, cyc_ph[i + 1]});
            end
        end

        // Farm traffic gone at FG entry -> FG shortened to the walk time.
        do_reset();
        c = 1;
        wait_phase("fg_short", S_FG, 40);
        c = 0;
        fg_len = 0;
        walk_cnt = 0;
        while (phase === S_FG && fg_len < 20) begin
            fg_len++;
            if (walk === 1'b1) walk_cnt++;
            tick("fg_short");
        end
        chk("fg_short_len", 8'(fg_len), 8'(4));
        chk("fg_short_walk", 8'(walk_cnt), 8'(4));
        chk("fg_short_after", {5'd0, phase}, {5'd0, S_FY});

        // Single pedestrian pulse at HG cnt=2 with no cars.
        do_reset();
        c = 0;
        tick("ped");
        tick("ped");
        ped_req = 1;
        tick("ped");
        ped_req = 0;
        for (int i = 0; i < 4; i++) tick("ped");
        chk("ped_hg_cnt7", {5'd0, phase}, {5'd0, S_HG});
        tick("ped");
        chk("ped_hy", {5'd0, phase}, {5'd0, S_HY});
        wait_phase("ped_fg", S_FG, 10);
        chk("ped_pend_clr", {7'd0, dut.ped_pend}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk("ped_walk", {7'd0, walk}, 8'd1);
            tick("ped");
        end
        chk("ped_fy", {5'd0, phase}, {5'd0, S_FY});
        wait_phase("ped_back", S_HG, 10);

        // Night flash from HG cnt=3.
        do_reset();
        for (int i = 0; i < 3; i++) tick("night");
        night = 1;
        tick("night");
        chk("night_flash", {5'd0, phase}, {5'd0, S_FLASH});
        flash_exp = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000};
        for (int i = 0; i < 8; i++) begin
            chk("flash_hwy", {5'd0, hwy}, {5'd0, flash_exp[i]});
            tick("night");
        end
        night = 0;
        tick("night");
        chk("night_ar2", {5'd0, phase}, {5'd0, S_AR2});
        tick("night");
        chk("night_ar2_b", {5'd0, phase}, {5'd0, S_AR2});
        tick("night");
        chk("night_hg", {5'd0, phase}, {5'd0, S_HG});

        // Reset in the middle of farm green.
        do_reset();
        c = 1;
        wait_phase("fg_rst", S_FG, 40);
        tick("fg_rst");
        #2 rst = 1;
        #1;
        chk("fg_rst_hwy", {5'd0, hwy}, 8'h01);
        chk("fg_rst_farm", {5'd0, farm}, 8'h04);
        chk("fg_rst_walk", {7'd0, walk}, 8'd0);
        chk("fg_rst_pend", {7'd0, dut.ped_pend}, 8'd0);
        model_reset();
        tick("fg_rst");
        rst = 0;
        c = 0;
        tick("fg_rst_resume");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 99) < 50);
            ped_req = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 3) night = ~night;
            if ($urandom_range(0, 999) < 3) do_reset();
            else tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
